ram_2p: RTL and testbench
=========================

Name: ram_2p

Overview:
- True dual-port synchronous RAM with two independent read/write ports, A and B, sharing one clock.
- Each port can write one word or read one word per cycle. Read data appears on a registered output.
- Used as a generic on-chip buffer: for example, port A fills the memory while port B drains it.

Parameters:
- AWID, 8, address width in bits for both ports.
- DEPTH, 256 (2**AWID), number of words; must satisfy DEPTH <= 2**AWID.
- DWID, 16, data word width in bits.
- Parameter declaration order is AWID, DEPTH, DWID, so positional override works.

Ports:
- clk  input  1  single clock for both ports; all activity on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_wea  input  1  port A write enable.
- i_addra  input  AWID  port A address.
- i_data  input  DWID  port A write data.
- o_data  output  DWID  port A registered read data.
- i_web  input  1  port B write enable.
- i_addrb  input  AWID  port B address.
- i_datb  input  DWID  port B write data.
- o_datb  output  DWID  port B registered read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - While rst_n=0, o_data and o_datb are forced to 0 immediately, with no clock edge required.
  - Memory contents are not cleared by reset; they persist across reset.
  - Writes presented while rst_n=0 are ignored.
- Write: at a rising clk with rst_n=1 and i_weX=1, mem[i_addrX] <= write data.
- Read:
  - Every rising clk with rst_n=1, each port registers mem[i_addrX] onto its output. This happens whether or not that port is writing.
  - Latency is 1 cycle: address presented at edge N gives data valid after edge N, held until edge N+1.
  - Output changes only at clock edges or on reset.
- Same-port read-during-write is read-first: o_data returns the word's previous content; the new value is visible on the next access.
- Cross-port access to the same address, one port writing, the other reading: the reader gets the old content (read-first).
- Both ports writing the same address in the same cycle: port A data wins; port B's write is dropped.
- Address >= DEPTH (only possible when DEPTH < 2**AWID):
  - Writes are ignored.
  - Reads return 0.
- Memory power-up contents are undefined. The bench must write before reading.
- No handshake: the block is always ready and never stalls.
- Implementation requirements:
  - The array is modelled as a reg array of DEPTH x DWID with no reset, so it infers block RAM.
  - Output registers carry the async reset.

Test Plan:
- Fill then read:
  - Port A writes mem[k]=k for k=0..255 on consecutive cycles; i_web held at 0.
  - After 10 idle cycles, port B sweeps i_addrb 0..255, one address per cycle.
  - Required: o_datb equals k one cycle after address k is presented, for all k.
- Reset:
  - Assert rst_n=0 mid-sweep, between clock edges.
  - Required: o_data and o_datb read 0 immediately.
  - After release, reading addr 0x10 returns 0x0010, showing contents retained.
- Same-port read-during-write: mem[5]=0x1234; port A writes 0xBEEF to addr 5.
  - Required: o_data=0x1234 after that edge.
  - The next read of addr 5 returns 0xBEEF.
- Cross-port collision:
  - Same edge, A writes 0xAAAA and B writes 0x5555 to addr 7. Required: a subsequent read on either port returns 0xAAAA.
  - Same edge, A writes 0x1111 to addr 9 (old value 0x0009) while B reads addr 9. Required: o_datb=0x0009.
- Both ports independent:
  - Same cycle, A writes addr 0x20=0xCAFE and B writes addr 0x21=0xF00D.
  - Required: both values read back correctly from the opposite port.
- Out-of-range (instance with DEPTH=200, AWID=8):
  - Write 0xFFFF to addr 250. Required: a read of addr 250 returns 0.
  - Required: addresses 0..199 are unaffected.

Source files
------------

// File: rtl/ram_2p.sv
// True dual-port synchronous RAM: two independent read/write ports on one clock,
// read-first on every port, registered read data with async-reset output stages.
module ram_2p #(
  parameter int AWID  = 8,
  parameter int DEPTH = 256,
  parameter int DWID  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wea,
  input  logic [AWID-1:0] i_addra,
  input  logic [DWID-1:0] i_data,
  output logic [DWID-1:0] o_data,
  input  logic            i_web,
  input  logic [AWID-1:0] i_addrb,
  input  logic [DWID-1:0] i_datb,
  output logic [DWID-1:0] o_datb
);

  // No handshake: both ports accept a read or write every cycle and never stall;
  // there is no valid/ready pair on this block.

  localparam logic [AWID:0] DEPTH_W = (AWID + 1)'(DEPTH);

  logic [DWID-1:0] mem [DEPTH];

  logic in_range_a;
  logic in_range_b;
  logic do_wr_a;
  logic do_wr_b;

  always_comb begin
    in_range_a = ({1'b0, i_addra} < DEPTH_W);
    in_range_b = ({1'b0, i_addrb} < DEPTH_W);
    do_wr_a    = rst_n && i_wea && in_range_a;
    do_wr_b    = rst_n && i_web && in_range_b;
  end

  // Array carries no reset so it maps onto block RAM. Port A is written last,
  // so on a same-address double write its data is the one that lands.
  always_ff @(posedge clk) begin
    if (do_wr_b) mem[i_addrb] <= i_datb;
    if (do_wr_a) mem[i_addra] <= i_data;
  end

  // Reads sample the array before this edge's writes land, giving read-first
  // behaviour on the same port and across ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
      o_datb <= '0;
    end else begin
      o_data <= in_range_a ? mem[i_addra] : '0;
      o_datb <= in_range_b ? mem[i_addrb] : '0;
    end
  end

endmodule

// File: tb/tb_ram_2p.sv
// Directed bench for ram_2p: fill/sweep, async reset, read-during-write,
// cross-port collisions, and out-of-range handling on a DEPTH=200 instance.
module tb_ram_2p;

  logic        clk;
  logic        rst_n;
  logic        wea, web;
  logic [7:0]  addra, addrb;
  logic [15:0] data_a, data_b;
  logic [15:0] q_a, q_b;

  logic        s_wea, s_web;
  logic [7:0]  s_addra, s_addrb;
  logic [15:0] s_data_a, s_data_b;
  logic [15:0] s_q_a, s_q_b;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  ram_2p #(.AWID(8), .DEPTH(256), .DWID(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_wea(wea), .i_addra(addra), .i_data(data_a), .o_data(q_a),
    .i_web(web), .i_addrb(addrb), .i_datb(data_b), .o_datb(q_b)
  );

  ram_2p #(.AWID(8), .DEPTH(200), .DWID(16)) u_dut_small (
    .clk(clk), .rst_n(rst_n),
    .i_wea(s_wea), .i_addra(s_addra), .i_data(s_data_a), .o_data(s_q_a),
    .i_web(s_web), .i_addrb(s_addrb), .i_datb(s_data_b), .o_datb(s_q_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    wea = 1'b0; web = 1'b0; addra = '0; addrb = '0; data_a = '0; data_b = '0;
    s_wea = 1'b0; s_web = 1'b0; s_addra = '0; s_addrb = '0; s_data_a = '0; s_data_b = '0;
  endtask

  task automatic write_a(input logic [7:0] a, input logic [15:0] d);
    wea = 1'b1; addra = a; data_a = d;
    tick();
    wea = 1'b0;
  endtask

  initial begin
    logic [15:0] exp;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_q_a", q_a, 16'h0000);
    check("reset_q_b", q_b, 16'h0000);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Fill mem[k]=k through port A
    for (int k = 0; k < 256; k++) begin
      wea = 1'b1; addra = 8'(k); data_a = 16'(k);
      tick();
    end
    wea = 1'b0;
    repeat (10) tick();

    // Sweep port B, reset mid-way
    for (int k = 0; k < 256; k++) begin
      addrb = 8'(k);
      exp_q.push_back(16'(k));
      tick();
      exp = exp_q.pop_front();
      check($sformatf("sweep_b[%0d]", k), q_b, exp);
      if (k == 128) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("midsweep_reset_q_a", q_a, 16'h0000);
        check("midsweep_reset_q_b", q_b, 16'h0000);
        // write presented during reset must be ignored
        wea = 1'b1; addra = 8'h10; data_a = 16'hDEAD;
        tick();
        check("reset_hold_q_a", q_a, 16'h0000);
        wea = 1'b0;
        rst_n = 1'b1;
        addrb = 8'h10;
        tick();
        check("retained_0x10", q_b, 16'h0010);
      end
    end

    // Same-port read-during-write
    write_a(8'd5, 16'h1234);
    wea = 1'b1; addra = 8'd5; data_a = 16'hBEEF;
    tick();
    check("rdw_a_old", q_a, 16'h1234);
    wea = 1'b0;
    tick();
    check("rdw_a_new", q_a, 16'hBEEF);

    // Both ports write the same address: A wins
    wea = 1'b1; addra = 8'd7; data_a = 16'hAAAA;
    web = 1'b1; addrb = 8'd7; data_b = 16'h5555;
    tick();
    wea = 1'b0; web = 1'b0;
    tick();
    check("collide_q_a", q_a, 16'hAAAA);
    check("collide_q_b", q_b, 16'hAAAA);

    // A writes while B reads same address: B sees old data
    wea = 1'b1; addra = 8'd9; data_a = 16'h1111;
    addrb = 8'd9;
    tick();
    check("xport_old_b", q_b, 16'h0009);
    wea = 1'b0;
    tick();
    check("xport_new_b", q_b, 16'h1111);

    // Independent writes, read back from the opposite port
    wea = 1'b1; addra = 8'h20; data_a = 16'hCAFE;
    web = 1'b1; addrb = 8'h21; data_b = 16'hF00D;
    tick();
    wea = 1'b0; web = 1'b0;
    addra = 8'h21; addrb = 8'h20;
    tick();
    check("indep_a_reads_21", q_a, 16'hF00D);
    check("indep_b_reads_20", q_b, 16'hCAFE);

    // Out-of-range on the DEPTH=200 instance
    for (int k = 0; k < 200; k++) begin
      s_wea = 1'b1; s_addra = 8'(k); s_data_a = 16'(k) ^ 16'h5A00;
      tick();
    end
    s_wea = 1'b1; s_addra = 8'd250; s_data_a = 16'hFFFF;
    s_web = 1'b1; s_addrb = 8'd251; s_data_b = 16'hFFFF;
    tick();
    s_wea = 1'b0; s_web = 1'b0;
    s_addra = 8'd251; s_addrb = 8'd250;
    tick();
    check("oor_read_250", s_q_b, 16'h0000);
    check("oor_read_251", s_q_a, 16'h0000);
    for (int k = 0; k < 200; k++) begin
      s_addrb = 8'(k);
      exp_q.push_back(16'(k) ^ 16'h5A00);
      tick();
      exp = exp_q.pop_front();
      check($sformatf("small_sweep[%0d]", k), s_q_b, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
